// File: rtl/ws2812_frame_tx.sv
// ws2812_frame_tx
//   Serialises one NUM_LEDS x 24-bit GRB frame onto a WS2812 data line, LED 0 first,
//   MSB (G7) first, then holds the line low for the latch period.
//
// Ports
//   clk    system clock
//   rst    asynchronous active-high reset
//   led    frame; LED n at led[n*24+23 : n*24], GRB, G7 at bit n*24+23
//   start  single-cycle transmit request (ignored while busy and on the done cycle)
//   dout   WS2812 serial data (registered)
//   busy   high from the cycle after an accepted start until done
//   done   one-cycle pulse at the end of the latch period
//
// Optional build macro: WS2812_BRIGHTNESS_EN
//   Adds input bright[2:0]; every colour byte is right-shifted by bright when the frame
//   is captured.
module ws2812_frame_tx #(
  parameter int unsigned NUM_LEDS = 64,
  parameter int unsigned T0H      = 40,
  parameter int unsigned T1H      = 80,
  parameter int unsigned TBIT     = 125,
  parameter int unsigned TRST     = 5000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_LEDS*24-1:0]   led,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [2:0]               bright,
`endif
  input  logic                     start,
  output logic                     dout,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned FrameW = NUM_LEDS * 24;
  localparam int unsigned IdxW   = (FrameW > 1) ? $clog2(FrameW) : 1;
  localparam int unsigned CycMax = (TBIT > TRST) ? TBIT : TRST;
  localparam int unsigned CycW   = (CycMax > 1) ? $clog2(CycMax) : 1;

  localparam logic [IdxW-1:0] IdxLast  = IdxW'(FrameW - 1);
  localparam logic [CycW-1:0] TbitLast = CycW'(TBIT - 1);
  localparam logic [CycW-1:0] TrstLast = CycW'(TRST - 1);
  localparam logic [CycW-1:0] T0hC     = CycW'(T0H);
  localparam logic [CycW-1:0] T1hC     = CycW'(T1H);

  typedef enum logic [1:0] {StIdle, StSend, StLatch} state_e;

  state_e              state_q, state_d;
  logic [FrameW-1:0]   frame_q, frame_d;
  logic [IdxW-1:0]     bit_idx_q, bit_idx_d;
  logic [4:0]          sub_q, sub_d;      // bit position within the current LED, 0..23
  logic [CycW-1:0]     cyc_q, cyc_d;
  logic                dout_q, dout_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [FrameW-1:0]   frame_in;

`ifdef WS2812_BRIGHTNESS_EN
  always_comb begin
    frame_in = led;
    for (int i = 0; i < NUM_LEDS * 3; i++) begin
      frame_in[i*8 +: 8] = led[i*8 +: 8] >> bright;
    end
  end
`else
  assign frame_in = led;
`endif

  // The bit on the wire is always frame_q[23]: the current LED's low 24 bits are shifted
  // left per bit, and the whole frame drops by one LED after its 24th bit.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_idx_d = bit_idx_q;
    sub_d     = sub_q;
    cyc_d     = cyc_q;
    dout_d    = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // done_q high means this is the done cycle; a start here is dropped.
        if (start && !done_q) begin
          frame_d   = frame_in;
          bit_idx_d = '0;
          sub_d     = '0;
          cyc_d     = '0;
          busy_d    = 1'b1;
          state_d   = StSend;
        end
      end
      StSend: begin
        dout_d = (cyc_q < (frame_q[23] ? T1hC : T0hC));
        if (cyc_q == TbitLast) begin
          cyc_d = '0;
          if (sub_q == 5'd23) begin
            frame_d = frame_q >> 24;
            sub_d   = '0;
          end else begin
            frame_d[23:0] = {frame_q[22:0], 1'b0};
            sub_d         = sub_q + 5'd1;
          end
          if (bit_idx_q == IdxLast) begin
            bit_idx_d = '0;
            state_d   = StLatch;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      StLatch: begin
        if (cyc_q == TrstLast) begin
          cyc_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      frame_q   <= '0;
      bit_idx_q <= '0;
      sub_q     <= '0;
      cyc_q     <= '0;
      dout_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_idx_q <= bit_idx_d;
      sub_q     <= sub_d;
      cyc_q     <= cyc_d;
      dout_q    <= dout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign dout = dout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_ws2812_frame_tx.sv
// Bench for ws2812_frame_tx, built with a reduced frame (4 LEDs, short bit times) so every
// frame runs to completion. Expected line levels come from the bit-timing rules applied to
// an arithmetic view of the frame.
module tb_ws2812_frame_tx;

  localparam int unsigned LN = 4;
  localparam int unsigned T0 = 4;
  localparam int unsigned T1 = 8;
  localparam int unsigned TB = 12;
  localparam int unsigned TR = 50;
  localparam int unsigned NB = LN * 24;
  localparam int unsigned SL = NB * TB;   // send length
  localparam int unsigned FL = SL + TR;   // edges from accept to done
`ifdef WS2812_BRIGHTNESS_EN
  localparam bit BrightEn = 1'b1;
`else
  localparam bit BrightEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NB-1:0] led;
  logic [2:0]    bright;
  logic          dout, busy, done;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  ws2812_frame_tx #(
    .NUM_LEDS (LN),
    .T0H      (T0),
    .T1H      (T1),
    .TBIT     (TB),
    .TRST     (TR)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .led    (led),
`ifdef WS2812_BRIGHTNESS_EN
    .bright (bright),
`endif
    .start  (start),
    .dout   (dout),
    .busy   (busy),
    .done   (done)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NB-1:0] rand_frame();
    logic [NB-1:0] r;
    for (int i = 0; i < NB / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [NB-1:0] scale(input logic [NB-1:0] f, input int unsigned b);
    logic [NB-1:0] r;
    for (int i = 0; i < NB / 8; i++) r[i*8 +: 8] = f[i*8 +: 8] >> b;
    return r;
  endfunction

  // j-th bit on the wire: LED j/24, colour bit 23 - j%24.
  function automatic logic wire_bit(input logic [NB-1:0] f, input int unsigned j);
    return f[(j / 24) * 24 + 23 - (j % 24)];
  endfunction

  // {dout, busy, done} seen after edge (accept + t).
  function automatic logic [2:0] exp_out(input logic [NB-1:0] f, input int unsigned t);
    logic d;
    d = 1'b0;
    if (t >= 1 && t - 1 < SL)
      d = ((t - 1) % TB) < (wire_bit(f, (t - 1) / TB) ? T1 : T0);
    return {d, (t < FL), (t == FL)};
  endfunction

  function automatic logic [NB-1:0] stream_of(input logic [NB-1:0] f);
    logic [NB-1:0] s;
    for (int j = 0; j < NB; j++) s[NB-1-j] = wire_bit(f, j);
    return s;
  endfunction

  // Sends one frame and checks every cycle; optional stray starts and led churn while busy,
  // plus a start on the done cycle. Returns the stream decoded from pulse widths.
  task automatic run_frame(input logic [NB-1:0] f, input logic [2:0] b, input bit disturb,
                           input string tag, output logic [NB-1:0] dec, output int nbits);
    logic [NB-1:0] ref_f;
    int run;
    ref_f = scale(f, BrightEn ? int'(b) : 0);
    dec = '0;
    nbits = 0;
    run = 0;
    @(negedge clk);
    led = f;
    bright = b;
    start = 1'b1;
    for (int unsigned t = 0; t <= FL + 2; t++) begin
      @(negedge clk);
      check_val({tag, "_line"}, {dout, busy, done}, exp_out(ref_f, t));
      if (dout) run++;
      else if (run > 0) begin
        dec = {dec[NB-2:0], (run > (T0 + T1) / 2)};
        nbits++;
        run = 0;
      end
      start = (disturb && (t == 300 || t == SL + 5)) || (t == FL);
      if (disturb && $urandom_range(0, 9) == 0) begin
        led = rand_frame();
        bright = 3'($urandom_range(0, 7));
      end
    end
    start = 1'b0;
    check_val({tag, "_nbits"}, nbits, NB);
    check_val({tag, "_stream"}, dec, stream_of(ref_f));
  endtask

  initial begin
    logic [NB-1:0] f, dec;
    int nbits;
    rst = 1'b1;
    start = 1'b0;
    led = '0;
    bright = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check_val("idle", {dout, busy, done}, 3'b000);
    end

    // Single '1' at LED0 G7.
    f = '0;
    f[23] = 1'b1;
    run_frame(f, 3'd0, 1'b0, "one", dec, nbits);
    check_val("one_first", dec[NB-1], 1'b1);

    // Bit ordering with stray starts and led churn while busy.
    f = '0;
    f[23:0] = 24'hA50000;
    f[(LN-1)*24 +: 24] = 24'h0000FF;
    run_frame(f, 3'd0, 1'b1, "order", dec, nbits);
    check_val("order_first8", dec[NB-1 -: 8], 8'hA5);
    check_val("order_last8", dec[7:0], 8'hFF);

    // Random frames, frames back to back.
    for (int k = 0; k < 2; k++) begin
      run_frame(rand_frame(), 3'($urandom_range(0, 7)), 1'b1, "rand", dec, nbits);
    end

    // Reset mid-frame, then a full fresh frame.
    @(negedge clk);
    led = rand_frame();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (300) @(negedge clk);
    check_val("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check_val("mid_rst", {dout, busy, done}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    f = rand_frame();
    f[23] = 1'b1;
    run_frame(f, 3'd0, 1'b0, "after_rst", dec, nbits);

    if (BrightEn) begin
      f = '0;
      f[23:0] = 24'hFF8001;
      run_frame(f, 3'd1, 1'b0, "bright", dec, nbits);
      check_val("bright_led0", dec[NB-1 -: 24], 24'h7F4000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
